// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// register-file selects, memory strobes, PC update and a MEM wait timeout.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             branch_cond,
  input  logic             mem_ack,
  output logic [4:0]       read_sel1,
  output logic [4:0]       read_sel2,
  output logic [4:0]       write_sel,
  output logic             rf_we,
  output logic             alu_src_imm,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd7
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           cur, nxt;
  logic [31:0]      ir;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic             err_q;

  logic             ir_load, cnt_clr, cnt_inc, set_err, retire;

  logic [5:0] op;
  logic [4:0] fld_a, fld_b, fld_c;
  logic       is_r, is_br, is_ialu, is_ld, is_st, is_nop;

  assign op    = ir[31:26];
  assign fld_a = ir[25:21];
  assign fld_b = ir[20:16];
  assign fld_c = ir[15:11];

  // Immediate bits feed the ALU datapath directly; the controller ignores them.
  logic unused_ir;
  assign unused_ir = ^{ir[10:0], op[2:1]};

  always_comb begin
    is_r    = (op[5:4] == 2'b01);
    is_br   = (op[5:4] == 2'b10);
    is_ialu = (op[5:4] == 2'b11) && !op[3];
    is_ld   = (op[5:4] == 2'b11) &&  op[3] && !op[0];
    is_st   = (op[5:4] == 2'b11) &&  op[3] &&  op[0];
    is_nop  = (op[5:4] == 2'b00);
  end

  always_comb begin
    read_sel1 = '0;
    read_sel2 = '0;
    write_sel = '0;
    if (is_r) begin
      read_sel1 = fld_a;
      read_sel2 = fld_b;
      write_sel = fld_c;
    end else if (is_br || is_st) begin
      read_sel1 = fld_a;
      read_sel2 = fld_b;
    end else if (is_ialu || is_ld) begin
      read_sel1 = fld_a;
      write_sel = fld_b;
    end
  end

  always_comb begin
    nxt         = cur;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    alu_src_imm = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    retire      = 1'b0;
    ir_load     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    set_err     = 1'b0;
    unique case (cur)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_load = 1'b1;
          nxt     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_nop) begin
          pc_inc = 1'b1;
          retire = 1'b1;
          nxt    = ST_FETCH;
        end else begin
          nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_src_imm = is_ialu || is_ld || is_st;
        if (is_br) begin
          pc_branch = branch_cond;
          pc_inc    = !branch_cond;
          retire    = 1'b1;
          nxt       = ST_FETCH;
        end else if (is_ld || is_st) begin
          cnt_clr = 1'b1;
          nxt     = ST_MEM;
        end else begin
          nxt = ST_WB;
        end
      end
      ST_MEM: begin
        mem_rd = is_ld;
        mem_wr = is_st;
        // An ack arriving on the final allowed cycle still completes the access.
        if (mem_ack) begin
          if (is_ld) begin
            nxt = ST_WB;
          end else begin
            pc_inc = 1'b1;
            retire = 1'b1;
            nxt    = ST_FETCH;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          set_err = 1'b1;
          nxt     = ST_ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_inc = 1'b1;
        retire = 1'b1;
        nxt    = ST_FETCH;
      end
      ST_ERR: begin
        nxt = ST_ERR;
      end
      default: begin
        nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= ST_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      ret_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      cur <= nxt;
      if (ir_load) begin
        ir <= instr;
      end
      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (retire) begin
        ret_cnt <= ret_cnt + 1'b1;
      end
    end
  end

  assign state   = cur;
  assign retired = ret_cnt;
  assign mem_err = err_q;

endmodule
